apb3_timer: RTL

APB3_TIMER -- requirements
Module: apb3_timer

---
 rtl/apb3_timer_pkg.sv | 34 +++
 rtl/apb3_timer_prescaler.sv | 42 ++++
 rtl/apb3_timer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/apb3_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb3_timer_pkg
// Purpose  : Register map, CTRL bit positions and register-index type
//            shared by the APB3 timer.
// Revision : 1.0
// ============================================================================
package apb3_timer_pkg;

   localparam logic [7:0] OFF_LOAD     = 8'h00;
   localparam logic [7:0] OFF_VALUE    = 8'h04;
   localparam logic [7:0] OFF_CTRL     = 8'h08;
   localparam logic [7:0] OFF_PRESCALE = 8'h0C;
   localparam logic [7:0] OFF_RIS      = 8'h10;
   localparam logic [7:0] OFF_INTCLR   = 8'h14;

   localparam int CTRL_WIDTH    = 3;
   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_BIT = 1;
   localparam int CTRL_IE_BIT   = 2;

   typedef enum logic [2:0] {
      REG_LOAD     = OFF_LOAD[4:2],
      REG_VALUE    = OFF_VALUE[4:2],
      REG_CTRL     = OFF_CTRL[4:2],
      REG_PRESCALE = OFF_PRESCALE[4:2],
      REG_RIS      = OFF_RIS[4:2],
      REG_INTCLR   = OFF_INTCLR[4:2],
      REG_RSVD6    = 3'd6,
      REG_RSVD7    = 3'd7
   } reg_idx_e;

endpackage
`default_nettype wire

// File: rtl/apb3_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : apb3_timer_prescaler
// Purpose  : Prescaler down-counter; emits a one-cycle tick when it hits 0
//            while enabled and reloads from PRESCALE on that same edge.
// Revision : 1.0
// ============================================================================
module apb3_timer_prescaler #(
   parameter int PRE_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 reload_i,
   input  logic [PRE_WIDTH-1:0] prescale_i,
   output logic                 tick_o
);

   logic [PRE_WIDTH-1:0] cnt_q;
   logic [PRE_WIDTH-1:0] cnt_d;

   assign tick_o = en_i && (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (reload_i || tick_o) begin
         cnt_d = prescale_i;
      end else if (en_i) begin
         cnt_d = cnt_q - PRE_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/apb3_timer.sv
`default_nettype none
// ============================================================================
// Module   : apb3_timer
// Purpose  : APB3 down-counting timer with prescaler, one-shot/periodic mode
//            and a registered interrupt. Define APB3_TIMER_PSLVERR_EN to
//            flag invalid accesses on PSLVERR.
// Revision : 1.0
// ============================================================================
module apb3_timer
   import apb3_timer_pkg::*;
#(
   parameter int APB_DWIDTH = 32,
   parameter int CNT_WIDTH  = 32,
   parameter int PRE_WIDTH  = 8
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [7:0]            PADDR,
   input  logic [APB_DWIDTH-1:0] PWDATA,
   output logic [APB_DWIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   output logic                  TIMINT
);

   logic [CNT_WIDTH-1:0]  load_q, load_d;
   logic [CNT_WIDTH-1:0]  value_q, value_d;
   logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
   logic [PRE_WIDTH-1:0]  prescale_q, prescale_d;
   logic                  ris_q, ris_d;
   logic                  timint_q;

   reg_idx_e              idx;
   logic                  wr_en;
   logic                  load_wr;
   logic                  intclr;
   logic                  tick;
   logic                  expire;
   logic [APB_DWIDTH-1:0] rdata;
   logic                  unused_bits;

   assign idx     = reg_idx_e'(PADDR[4:2]);
   assign wr_en   = PSEL && PENABLE && PWRITE;
   assign load_wr = wr_en && (idx == REG_LOAD);
   assign intclr  = wr_en && (idx == REG_INTCLR) && PWDATA[0];
   // A LOAD write on a tick edge swallows that tick entirely.
   assign expire  = tick && !load_wr && (value_q == CNT_WIDTH'(1));

   apb3_timer_prescaler #(
      .PRE_WIDTH (PRE_WIDTH)
   ) u_prescaler (
      .clk_i      (PCLK),
      .rst_i      (PRESET),
      .en_i       (ctrl_q[CTRL_EN_BIT]),
      .reload_i   (load_wr),
      .prescale_i (prescale_q),
      .tick_o     (tick)
   );

   always_comb begin
      load_d     = load_q;
      value_d    = value_q;
      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      if (load_wr) begin
         value_d = PWDATA[CNT_WIDTH-1:0];
      end else if (tick) begin
         if (value_q > CNT_WIDTH'(1)) begin
            value_d = value_q - CNT_WIDTH'(1);
         end else if (ctrl_q[CTRL_MODE_BIT]) begin
            value_d = load_q;
         end else if (value_q == CNT_WIDTH'(1)) begin
            value_d             = '0;
            ctrl_d[CTRL_EN_BIT] = 1'b0;
         end
      end
      // A software CTRL write wins over the one-shot auto-disable.
      if (wr_en) begin
         case (idx)
            REG_LOAD:     load_d     = PWDATA[CNT_WIDTH-1:0];
            REG_CTRL:     ctrl_d     = PWDATA[CTRL_WIDTH-1:0];
            REG_PRESCALE: prescale_d = PWDATA[PRE_WIDTH-1:0];
            default:      ;
         endcase
      end
      ris_d = expire || (ris_q && !intclr);
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         load_q     <= '0;
         value_q    <= '0;
         ctrl_q     <= '0;
         prescale_q <= '0;
         ris_q      <= 1'b0;
         timint_q   <= 1'b0;
      end else begin
         load_q     <= load_d;
         value_q    <= value_d;
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         ris_q      <= ris_d;
         timint_q   <= ris_q && ctrl_q[CTRL_IE_BIT];
      end
   end

   always_comb begin
      rdata = '0;
      if (PSEL && !PWRITE && !PRESET) begin
         case (idx)
            REG_LOAD:     rdata[CNT_WIDTH-1:0]  = load_q;
            REG_VALUE:    rdata[CNT_WIDTH-1:0]  = value_q;
            REG_CTRL:     rdata[CTRL_WIDTH-1:0] = ctrl_q;
            REG_PRESCALE: rdata[PRE_WIDTH-1:0]  = prescale_q;
            REG_RIS:      rdata[0]              = ris_q;
            default:      ;
         endcase
      end
   end

`ifdef APB3_TIMER_PSLVERR_EN
   assign PSLVERR = PSEL && PENABLE && !PRESET &&
                    ((idx == REG_RSVD6) || (idx == REG_RSVD7) ||
                     (PWRITE && ((idx == REG_VALUE) || (idx == REG_RIS))));
`else
   assign PSLVERR = 1'b0;
`endif

   assign PRDATA      = rdata;
   assign PREADY      = 1'b1;
   assign TIMINT      = timint_q;
   assign unused_bits = ^{PADDR[7:5], PADDR[1:0], PWDATA};

endmodule
`default_nettype wire
